// File: rtl/voxel_bank_ram.sv
// Purpose: word-packed voxel occupancy RAM with masked loader writes, NUM_RD single-bit read ports, bulk clear and load progress.
// Latency: reads return 1 cycle after request; writes land at the accepting edge; clear takes exactly NWORDS cycles.
// Backpressure: load_ready drops while clearing, when a clear is requested, or when load_mode is low; reads never stall.
module voxel_bank_ram #(
  parameter int ADDR_BITS   = 15,
  parameter int WORD_BITS   = 32,
  parameter int NUM_RD      = 2,
  parameter int WRITE_FIRST = 1,
  localparam int WB         = $clog2(WORD_BITS),
  localparam int WA_RAW     = ADDR_BITS - WB,
  localparam int WA         = (WA_RAW < 1) ? 1 : WA_RAW
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clear_start,
  output logic                        clear_busy,
  input  logic                        load_mode,
  input  logic                        load_valid,
  output logic                        load_ready,
  input  logic [WA-1:0]               load_waddr,
  input  logic [WORD_BITS-1:0]        load_wdata,
  input  logic [WORD_BITS-1:0]        load_wmask,
  input  logic [NUM_RD-1:0]           rd_valid,
  input  logic [NUM_RD*ADDR_BITS-1:0] rd_addr,
  output logic [NUM_RD-1:0]           rd_rvalid,
  output logic [NUM_RD-1:0]           rd_data,
  output logic [WA:0]                 words_written,
  output logic                        load_complete
);

  localparam int NWORDS             = (1 << ADDR_BITS) / WORD_BITS;
  localparam int NMEM               = 1 << WA;
  localparam int WB_W               = (WB < 1) ? 1 : WB;
  localparam logic [WA:0]   NWORDS_CNT = (WA+1)'(NWORDS);
  localparam logic [WA-1:0] LAST_IDX   = WA'(NWORDS - 1);
  localparam logic [WB_W-1:0] BIT_MASK = WB_W'(WORD_BITS - 1);

  typedef enum logic {S_IDLE, S_CLEAR} state_t;

  state_t                 r_state, w_state_nxt;
  logic [WA-1:0]          r_idx, w_idx_nxt;
  logic [WORD_BITS-1:0]   r_mem [NMEM];
  logic [NUM_RD-1:0]      r_rvalid, r_rdata, w_rd_bit;
  logic [WA:0]            r_words;
  logic                   r_complete;

  logic                   w_load_acc;
  logic                   w_wr_en;
  logic [WA-1:0]          w_wr_idx;
  logic [WORD_BITS-1:0]   w_wr_mask, w_wr_data, w_wr_merged;

  assign clear_busy    = (r_state == S_CLEAR);
  assign load_ready    = load_mode && (r_state == S_IDLE) && !clear_start;
  assign w_load_acc    = load_valid && load_ready;
  assign rd_rvalid     = r_rvalid;
  assign rd_data       = r_rdata;
  assign words_written = r_words;
  assign load_complete = r_complete;

  // Single write port shared by the clear sequencer (zero whole word) and the loader (masked merge).
  assign w_wr_en     = w_load_acc || clear_busy;
  assign w_wr_idx    = clear_busy ? r_idx : load_waddr;
  assign w_wr_mask   = clear_busy ? '1 : load_wmask;
  assign w_wr_data   = clear_busy ? '0 : load_wdata;
  assign w_wr_merged = (r_mem[w_wr_idx] & ~w_wr_mask) | (w_wr_data & w_wr_mask);

  // Clear sequencer state register; an async reset abandons a clear part way through.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  // Next-state: one word zeroed per cycle, return to IDLE after the last word.
  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (clear_start) begin
          w_state_nxt = S_CLEAR;
          w_idx_nxt   = '0;
        end
      end
      S_CLEAR: begin
        w_idx_nxt = r_idx + 1'b1;
        if (r_idx == LAST_IDX) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Storage array; contents deliberately survive reset.
  always_ff @(posedge clk) begin
    if (w_wr_en) r_mem[w_wr_idx] <= w_wr_merged;
  end

  // Per-port bit lookup, with optional bypass of the same-cycle write.
  for (genvar g = 0; g < NUM_RD; g++) begin : g_rd
    logic [ADDR_BITS-1:0] w_addr;
    logic [WA-1:0]        w_word;
    logic [WB_W-1:0]      w_bit;
    logic [WORD_BITS-1:0] w_cur;
    assign w_addr = rd_addr[g*ADDR_BITS +: ADDR_BITS];
    assign w_word = WA'(w_addr >> WB);
    assign w_bit  = WB_W'(w_addr) & BIT_MASK;
    assign w_cur  = ((WRITE_FIRST != 0) && w_wr_en && (w_wr_idx == w_word)) ? w_wr_merged
                                                                           : r_mem[w_word];
    assign w_rd_bit[g] = w_cur[w_bit];
  end

  // Read response registers; data holds when a port is not requesting.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rvalid <= '0;
      r_rdata  <= '0;
    end else begin
      r_rvalid <= rd_valid;
      for (int i = 0; i < NUM_RD; i++) begin
        if (rd_valid[i]) r_rdata[i] <= w_rd_bit[i];
      end
    end
  end

  // Load progress: restart on leaving load mode or starting a clear, else count accepts up to NWORDS.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_words    <= '0;
      r_complete <= 1'b0;
    end else if (!load_mode || ((r_state == S_IDLE) && clear_start)) begin
      r_words    <= '0;
      r_complete <= 1'b0;
    end else if (w_load_acc && (r_words != NWORDS_CNT)) begin
      r_words <= r_words + 1'b1;
      if ((r_words + 1'b1) == NWORDS_CNT) r_complete <= 1'b1;
    end
  end

endmodule

// File: tb/tb_voxel_bank_ram.sv
// Purpose: directed self-checking bench for voxel_bank_ram, two instances differing only in WRITE_FIRST.
// Latency: samples outputs 1 time unit after each rising edge.
// Backpressure: drives load_valid and observes load_ready combinationally.
module tb_voxel_bank_ram;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        clear_start, load_mode, load_valid;
  logic [9:0]  load_waddr;
  logic [31:0] load_wdata, load_wmask;
  logic [1:0]  rd_valid;
  logic [29:0] rd_addr;

  logic        a_busy, a_ready, a_complete;
  logic [1:0]  a_rvalid, a_rdata;
  logic [10:0] a_words;
  logic        b_busy, b_ready, b_complete;
  logic [1:0]  b_rvalid, b_rdata;
  logic [10:0] b_words;

  int n_pass  = 0;
  int n_total = 0;
  int n;

  always #5 clk = ~clk;

  voxel_bank_ram #(.ADDR_BITS(15), .WORD_BITS(32), .NUM_RD(2), .WRITE_FIRST(1)) u_dut_wf1 (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(a_busy),
    .load_mode(load_mode), .load_valid(load_valid), .load_ready(a_ready),
    .load_waddr(load_waddr), .load_wdata(load_wdata), .load_wmask(load_wmask),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_rvalid(a_rvalid), .rd_data(a_rdata),
    .words_written(a_words), .load_complete(a_complete)
  );

  voxel_bank_ram #(.ADDR_BITS(15), .WORD_BITS(32), .NUM_RD(2), .WRITE_FIRST(0)) u_dut_wf0 (
    .clk(clk), .rst_n(rst_n), .clear_start(clear_start), .clear_busy(b_busy),
    .load_mode(load_mode), .load_valid(load_valid), .load_ready(b_ready),
    .load_waddr(load_waddr), .load_wdata(load_wdata), .load_wmask(load_wmask),
    .rd_valid(rd_valid), .rd_addr(rd_addr), .rd_rvalid(b_rvalid), .rd_data(b_rdata),
    .words_written(b_words), .load_complete(b_complete)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rd2(input logic [14:0] a0, input logic [14:0] a1);
    rd_valid = 2'b11;
    rd_addr  = {a1, a0};
    step();
    rd_valid = 2'b00;
  endtask

  task automatic wr(input logic [9:0] wa, input logic [31:0] d, input logic [31:0] m);
    load_valid = 1'b1;
    load_waddr = wa;
    load_wdata = d;
    load_wmask = m;
    step();
    load_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clear_start = 0; load_mode = 0; load_valid = 0;
    load_waddr = '0; load_wdata = '0; load_wmask = '0; rd_valid = '0; rd_addr = '0;
    repeat (2) @(posedge clk);
    #1;
    n_total++;
    if ({a_busy, a_rvalid, a_rdata, a_words, a_complete} !== 16'h0)
      $display("FAIL reset_state got=%h exp=0", {a_busy, a_rvalid, a_rdata, a_words, a_complete});
    else n_pass++;
    #2 rst_n = 1'b1;
    step();
  endtask

  task automatic test_clear_defaults();
    logic [14:0] addrs [8] = '{15'd0, 15'd77, 15'd1234, 15'd5000, 15'd16383, 15'd20000, 15'd31000, 15'd32767};
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    n = 0;
    while (a_busy === 1'b1 && n < 2000) begin
      n++;
      step();
    end
    n_total++;
    if (n !== 1024) $display("FAIL clear_len got=%0d exp=1024", n); else n_pass++;
    for (int i = 0; i < 8; i++) begin
      rd2(addrs[i], addrs[7-i]);
      n_total++;
      if ({a_rvalid, a_rdata} !== 4'b1100)
        $display("FAIL clear_read%0d got=%b exp=1100", i, {a_rvalid, a_rdata});
      else n_pass++;
    end
    step();
    n_total++;
    if (a_rvalid !== 2'b00) $display("FAIL rvalid_drop got=%b exp=00", a_rvalid); else n_pass++;
  endtask

  task automatic test_masked_write();
    load_mode = 1'b1;
    wr(10'd5, 32'hFFFF_FFFF, 32'h0000_00F0);
    rd2(15'd164, 15'd165);
    n_total++;
    if (a_rdata !== 2'b11) $display("FAIL mask_164_165 got=%b exp=11", a_rdata); else n_pass++;
    rd2(15'd166, 15'd167);
    n_total++;
    if (a_rdata !== 2'b11) $display("FAIL mask_166_167 got=%b exp=11", a_rdata); else n_pass++;
    rd2(15'd160, 15'd168);
    n_total++;
    if (a_rdata !== 2'b00) $display("FAIL mask_160_168 got=%b exp=00", a_rdata); else n_pass++;
    wr(10'd5, 32'h0, 32'h0000_0010);
    rd2(15'd164, 15'd165);
    n_total++;
    if (a_rdata !== 2'b10) $display("FAIL mask_clear_bit got=%b exp=10", a_rdata); else n_pass++;
  endtask

  task automatic test_collision();
    load_valid = 1'b1; load_waddr = 10'd1; load_wdata = 32'h2; load_wmask = 32'h2;
    rd_valid = 2'b01; rd_addr = {15'd0, 15'd33};
    step();
    load_valid = 1'b0; rd_valid = 2'b00;
    n_total++;
    if (a_rdata[0] !== 1'b1) $display("FAIL coll_wf1 got=%b exp=1", a_rdata[0]); else n_pass++;
    n_total++;
    if (b_rdata[0] !== 1'b0) $display("FAIL coll_wf0 got=%b exp=0", b_rdata[0]); else n_pass++;
    rd2(15'd33, 15'd32);
    n_total++;
    if ({b_rdata, a_rdata} !== 4'b0101) $display("FAIL coll_after got=%b exp=0101", {b_rdata, a_rdata}); else n_pass++;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    step();
    rd_valid = 2'b01; rd_addr = {15'd0, 15'd33};
    step();
    rd_valid = 2'b00;
    n_total++;
    if (a_rdata[0] !== 1'b0) $display("FAIL coll_clear_wf1 got=%b exp=0", a_rdata[0]); else n_pass++;
    n_total++;
    if (b_rdata[0] !== 1'b1) $display("FAIL coll_clear_wf0 got=%b exp=1", b_rdata[0]); else n_pass++;
    n = 0;
    while (a_busy === 1'b1 && n < 2000) begin n++; step(); end
    n_total++;
    if (a_busy !== 1'b0) $display("FAIL coll_clear_end got=%b exp=0", a_busy); else n_pass++;
  endtask

  task automatic test_load_progress();
    load_mode = 1'b0;
    step();
    load_mode = 1'b1;
    #1;
    n_total++;
    if (a_ready !== 1'b1) $display("FAIL ready_idle got=%b exp=1", a_ready); else n_pass++;
    load_valid = 1'b1; load_wdata = 32'h8000_0001; load_wmask = 32'hFFFF_FFFF;
    for (int i = 0; i < 1024; i++) begin
      load_waddr = 10'(i);
      if (i == 1023) begin
        n_total++;
        if ({a_words, a_complete} !== {11'd1023, 1'b0})
          $display("FAIL load_1023 got=%0d/%b exp=1023/0", a_words, a_complete);
        else n_pass++;
      end
      step();
    end
    n_total++;
    if ({a_words, a_complete} !== {11'd1024, 1'b1})
      $display("FAIL load_done got=%0d/%b exp=1024/1", a_words, a_complete);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin load_waddr = 10'(i); step(); end
    n_total++;
    if ({a_words, a_complete} !== {11'd1024, 1'b1})
      $display("FAIL load_sat got=%0d/%b exp=1024/1", a_words, a_complete);
    else n_pass++;
    load_valid = 1'b0; load_mode = 1'b0;
    step();
    n_total++;
    if ({a_words, a_complete} !== 12'h0)
      $display("FAIL load_drop got=%0d/%b exp=0/0", a_words, a_complete);
    else n_pass++;
  endtask

  task automatic test_arbitration();
    load_mode = 1'b1;
    wr(10'd9, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    n_total++;
    if (a_words !== 11'd1) $display("FAIL arb_pre_count got=%0d exp=1", a_words); else n_pass++;
    clear_start = 1'b1; load_valid = 1'b1; load_waddr = 10'd7;
    load_wdata = 32'hFFFF_FFFF; load_wmask = 32'hFFFF_FFFF;
    #1;
    n_total++;
    if (a_ready !== 1'b0) $display("FAIL arb_ready_start got=%b exp=0", a_ready); else n_pass++;
    step();
    clear_start = 1'b0;
    n = (a_busy === 1'b1) ? 1 : 0;
    n_total++;
    if (a_words !== 11'd0) $display("FAIL arb_count_reset got=%0d exp=0", a_words); else n_pass++;
    n_total++;
    if (a_ready !== 1'b0) $display("FAIL arb_ready_mid got=%b exp=0", a_ready); else n_pass++;
    rd2(15'd229, 15'd293);
    if (a_busy === 1'b1) n++;
    n_total++;
    if (a_rdata !== 2'b10) $display("FAIL arb_no_write got=%b exp=10", a_rdata); else n_pass++;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    if (a_busy === 1'b1) n++;
    while (a_busy === 1'b1 && n < 2000) begin step(); if (a_busy === 1'b1) n++; end
    load_valid = 1'b0;
    n_total++;
    if (n !== 1024) $display("FAIL arb_clear_len got=%0d exp=1024", n); else n_pass++;
    n_total++;
    if (a_words !== 11'd0) $display("FAIL arb_no_accept got=%0d exp=0", a_words); else n_pass++;
    for (int w = 295; w <= 305; w++) wr(10'(w), 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    load_mode = 1'b0;
    clear_start = 1'b1;
    step();
    clear_start = 1'b0;
    repeat (300) step();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({a_busy, b_busy} !== 2'b00) $display("FAIL arb_reset_busy got=%b exp=00", {a_busy, b_busy}); else n_pass++;
    #1 rst_n = 1'b1;
    step();
    rd2(15'd9599, 15'd9600);
    n_total++;
    if (a_rdata !== 2'b10) $display("FAIL arb_partial_a got=%b exp=10", a_rdata); else n_pass++;
    rd2(15'd9791, 15'd9440);
    n_total++;
    if (a_rdata !== 2'b01) $display("FAIL arb_partial_b got=%b exp=01", a_rdata); else n_pass++;
  endtask

  task automatic test_hold();
    logic [14:0] p0_addr [5] = '{15'd9632, 15'd3200, 15'd9791, 15'd9568, 15'd9671};
    logic        p0_exp  [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
    rd_valid = 2'b10; rd_addr = {15'd9604, 15'd0};
    step();
    n_total++;
    if ({a_rvalid, a_rdata} !== 4'b1011) $display("FAIL hold_setup got=%b exp=1011", {a_rvalid, a_rdata}); else n_pass++;
    for (int i = 0; i < 5; i++) begin
      rd_valid = 2'b01; rd_addr = {15'd3200, p0_addr[i]};
      step();
      n_total++;
      if ({a_rvalid, a_rdata} !== {2'b01, 1'b1, p0_exp[i]})
        $display("FAIL hold_cycle%0d got=%b exp=%b", i, {a_rvalid, a_rdata}, {2'b01, 1'b1, p0_exp[i]});
      else n_pass++;
    end
    rd_valid = 2'b00;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_clear_defaults();
    test_masked_write();
    test_collision();
    test_load_progress();
    test_arbitration();
    test_hold();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
